// File: rtl/baud_pkg.sv
// Shared constants for the fractional baud generator.
// CLK_HZ plus the default divisor (54 + 4/16 clocks per oversample tick gives
// 115200 baud x16 at 100 MHz), the default oversample ratio and default widths.
package baud_pkg;

  localparam int unsigned CLK_HZ       = 100_000_000;
  localparam int unsigned DEF_DIV_INT  = 54;
  localparam int unsigned DEF_DIV_FRAC = 4;
  localparam int unsigned DEF_OVS      = 16;
  localparam int unsigned DEF_CNT_W    = 16;
  localparam int unsigned DEF_FRAC_W   = 4;

  // Shortest oversample period the counter can produce.
  localparam int unsigned MIN_PERIOD   = 2;

endpackage

// File: rtl/frac_acc.sv
// Fractional divisor accumulator.
// On every step the fraction is added into acc modulo 2^FRAC_W; the carry-out
// is held in carry for exactly one following period (until the next step).
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous active-high reset (acc = 0, carry = 0)
//   step   - one-cycle strobe, accumulate frac
//   frac   - fractional increment in units of 1/2^FRAC_W
//   clear  - synchronous clear of acc and carry (phase realignment)
//   carry  - stretch the next period by one clock
module frac_acc #(
  parameter int unsigned FRAC_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              step,
  input  logic [FRAC_W-1:0] frac,
  input  logic              clear,
  output logic              carry
);

  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              carry_q, carry_d;

  always_comb begin
    acc_d   = acc_q;
    carry_d = carry_q;
    if (clear) begin
      acc_d   = '0;
      carry_d = 1'b0;
    end else if (step) begin
      {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, frac};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      carry_q <= carry_d;
    end
  end

  assign carry = carry_q;

endmodule

// File: rtl/frac_baud_gen.sv
// Fractional-N baud rate generator with oversample, midpoint and bit strobes.
// Mean oversample period is active_int + active_frac/2^FRAC_W clocks; the
// fraction is dithered in by stretching single periods by one clock.
// Ports:
//   clock, reset        - rising-edge clock, synchronous active-high reset
//   enable              - count when high; freeze all state and ticks when low
//   restart             - realign bit phase (counter, accumulator, phase to 0)
//   load                - capture div_int/div_frac into the pending shadow
//   div_int, div_frac   - new divisor, integer and fractional parts
//   tick_ovs            - oversample tick
//   tick_mid, tick_bit  - tick_ovs at bit midpoint / last slot of the bit
//   phase               - oversample slot within the bit
//   cfg_pending         - a loaded divisor is waiting to be applied
// OVS must be a power of two >= 4 so phase wraps naturally.
module frac_baud_gen
  import baud_pkg::*;
#(
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter int unsigned FRAC_W = DEF_FRAC_W,
  parameter int unsigned OVS    = DEF_OVS
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    restart,
  input  logic                    load,
  input  logic [CNT_W-1:0]        div_int,
  input  logic [FRAC_W-1:0]       div_frac,
  output logic                    tick_ovs,
  output logic                    tick_mid,
  output logic                    tick_bit,
  output logic [$clog2(OVS)-1:0]  phase,
  output logic                    cfg_pending
);

  localparam int unsigned PhW = $clog2(OVS);
  // One extra bit so active_int = 2^CNT_W-1 plus a carry still fits.
  localparam int unsigned PW  = CNT_W + 1;

  logic [CNT_W-1:0]  act_int_q, pend_int_q;
  logic [FRAC_W-1:0] act_frac_q, pend_frac_q;
  logic              pend_q;
  logic [PW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     eff_int, period;
  logic [PhW-1:0]    phase_q, phase_d;
  logic              carry;
  logic              tick;
  logic              apply;

  // Divisors below the minimum are clamped rather than rejected.
  assign eff_int = (act_int_q < CNT_W'(MIN_PERIOD)) ? PW'(MIN_PERIOD) : {1'b0, act_int_q};
  assign period  = eff_int + PW'(carry);

  assign tick  = enable & ~restart & ~reset & (cnt_q == period);
  // Disabled generator has no period boundary to wait for, so apply at once.
  assign apply = pend_q & (tick | ~enable);

  frac_acc #(
    .FRAC_W (FRAC_W)
  ) u_frac_acc (
    .clock (clock),
    .reset (reset),
    .step  (tick),
    .frac  (act_frac_q),
    .clear (restart),
    .carry (carry)
  );

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (restart) begin
      cnt_d   = PW'(1);
      phase_d = '0;
    end else if (tick) begin
      cnt_d   = PW'(1);
      phase_d = phase_q + PhW'(1);
    end else if (enable) begin
      cnt_d   = cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= PW'(1);
      phase_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  // Config shadow: the active divisor only changes on a period boundary, and a
  // load in the same cycle as that boundary waits for the next one.
  always_ff @(posedge clock) begin
    if (reset) begin
      act_int_q   <= CNT_W'(DEF_DIV_INT);
      act_frac_q  <= FRAC_W'(DEF_DIV_FRAC);
      pend_int_q  <= CNT_W'(DEF_DIV_INT);
      pend_frac_q <= FRAC_W'(DEF_DIV_FRAC);
      pend_q      <= 1'b0;
    end else begin
      if (apply) begin
        act_int_q  <= pend_int_q;
        act_frac_q <= pend_frac_q;
      end
      if (load) begin
        pend_int_q  <= div_int;
        pend_frac_q <= div_frac;
      end
      pend_q <= load | (pend_q & ~apply);
    end
  end

  assign tick_ovs    = tick;
  assign tick_bit    = tick & (phase_q == PhW'(OVS - 1));
  assign tick_mid    = tick & (phase_q == PhW'(OVS / 2 - 1));
  assign phase       = phase_q;
  assign cfg_pending = pend_q;

endmodule

// File: tb/tb_frac_baud_gen.sv
// Directed bench for frac_baud_gen: expected tick gaps are queued as stimulus
// is set up and popped as each tick_ovs is observed.
module tb_frac_baud_gen;

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned FRAC_W = 4;
  localparam int unsigned OVS    = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic              enable;
  logic              restart;
  logic              load;
  logic [CNT_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              tick_ovs;
  logic              tick_mid;
  logic              tick_bit;
  logic [3:0]        phase;
  logic              cfg_pending;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_tick;
  int gap_q[$];
  int span;

  int         t_gap;
  logic       t_ok;
  logic       t_mid;
  logic       t_bit;
  logic [3:0] t_phase;

  frac_baud_gen #(
    .CNT_W  (CNT_W),
    .FRAC_W (FRAC_W),
    .OVS    (OVS)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .restart     (restart),
    .load        (load),
    .div_int     (div_int),
    .div_frac    (div_frac),
    .tick_ovs    (tick_ovs),
    .tick_mid    (tick_mid),
    .tick_bit    (tick_bit),
    .phase       (phase),
    .cfg_pending (cfg_pending)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the next tick_ovs, sampling on the falling edge.
  task automatic wait_tick();
    int n;
    n    = 0;
    t_ok = 1'b0;
    while (!t_ok && n < 400) begin
      @(negedge clock);
      n++;
      if (tick_ovs === 1'b1) begin
        t_ok      = 1'b1;
        t_gap     = cyc - last_tick;
        last_tick = cyc;
        t_mid     = tick_mid;
        t_bit     = tick_bit;
        t_phase   = phase;
      end
    end
  endtask

  task automatic check_gap(input string tag);
    int exp;
    wait_tick();
    chk({tag, " seen"}, 32'(t_ok), 1);
    exp = (gap_q.size() > 0) ? gap_q.pop_front() : -1;
    chk({tag, " gap"}, t_gap, exp);
  endtask

  // Mark the cycle after the current edge as period cycle 1 (counter = 1).
  task automatic mark_start();
    last_tick = cyc - 1;
  endtask

  initial begin
    reset    = 1'b1;
    enable   = 1'b1;
    restart  = 1'b0;
    load     = 1'b0;
    div_int  = '0;
    div_frac = '0;
    last_tick = 0;

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst tick_ovs", 32'(tick_ovs), 0);
    chk("rst phase", 32'(phase), 0);
    chk("rst cfg_pending", 32'(cfg_pending), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    mark_start();

    // Defaults 54 + 4/16: gaps 54,54,54,55 repeating; 16 gaps span 868
    gap_q.push_back(54);
    for (int i = 1; i <= 16; i++) gap_q.push_back((i % 4 == 0) ? 55 : 54);
    span = 0;
    for (int k = 1; k <= 17; k++) begin
      check_gap($sformatf("dflt k%0d", k));
      if (k > 1) span += t_gap;
      chk($sformatf("dflt phase k%0d", k), 32'(t_phase), (k - 1) % 16);
      chk($sformatf("dflt bit k%0d", k), 32'(t_bit), (k == 16) ? 1 : 0);
      chk($sformatf("dflt mid k%0d", k), 32'(t_mid), (k == 8) ? 1 : 0);
    end
    chk("dflt span16", span, 868);

    // Mid-period load of 10/0: current period stays 54, then 10
    repeat (20) @(posedge clock);
    #1;
    div_int  = 16'd10;
    div_frac = 4'd0;
    load     = 1'b1;
    @(posedge clock); #1;
    load = 1'b0;
    @(negedge clock);
    chk("load pending", 32'(cfg_pending), 1);
    gap_q.push_back(54);
    check_gap("load old");
    @(negedge clock);
    chk("load applied", 32'(cfg_pending), 0);
    gap_q.push_back(10);
    check_gap("load new");

    // Advance phase to 9 (phase now 3 after 19 ticks)
    for (int k = 0; k < 6; k++) begin
      gap_q.push_back(10);
      check_gap($sformatf("pre-restart k%0d", k));
    end
    // Restart in the cycle the next tick would fire
    repeat (10) @(posedge clock);
    #1;
    restart = 1'b1;
    @(negedge clock);
    chk("restart tick", 32'(tick_ovs), 0);
    chk("restart old phase", 32'(phase), 9);
    @(posedge clock); #1;
    restart = 1'b0;
    mark_start();
    @(negedge clock);
    chk("restart phase", 32'(phase), 0);
    for (int k = 1; k <= 16; k++) begin
      gap_q.push_back(10);
      check_gap($sformatf("rs k%0d", k));
      chk($sformatf("rs mid k%0d", k), 32'(t_mid), (k == 8) ? 1 : 0);
      chk($sformatf("rs bit k%0d", k), 32'(t_bit), (k == 16) ? 1 : 0);
    end

    // div_int = 0 clamps to 2
    @(posedge clock); #1;
    div_int = 16'd0;
    load    = 1'b1;
    @(posedge clock); #1;
    load = 1'b0;
    gap_q.push_back(10);
    gap_q.push_back(2);
    gap_q.push_back(2);
    gap_q.push_back(2);
    for (int k = 0; k < 4; k++) check_gap($sformatf("clamp k%0d", k));

    // Enable low for 5 cycles where the tick would fire: gap grows to 7
    @(posedge clock); #1;
    @(posedge clock); #1;
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk($sformatf("frozen tick c%0d", i), 32'(tick_ovs), 0);
      @(posedge clock); #1;
    end
    enable = 1'b1;
    gap_q.push_back(7);
    gap_q.push_back(2);
    check_gap("en stretch");
    check_gap("en resume");

    // Reset with a load pending (held by restart so it is not applied)
    @(posedge clock); #1;
    div_int = 16'd30;
    load    = 1'b1;
    @(posedge clock); #1;
    load    = 1'b0;
    restart = 1'b1;
    @(negedge clock);
    chk("prerst pending", 32'(cfg_pending), 1);
    @(posedge clock); #1;
    restart = 1'b0;
    reset   = 1'b1;
    load    = 1'b1;
    div_int = 16'd7;
    @(negedge clock);
    chk("inrst tick", 32'(tick_ovs), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    load  = 1'b0;
    mark_start();
    @(negedge clock);
    chk("postrst pending", 32'(cfg_pending), 0);
    chk("postrst ticks", 32'({tick_ovs, tick_mid, tick_bit}), 0);
    chk("postrst phase", 32'(phase), 0);
    gap_q.push_back(54);
    gap_q.push_back(54);
    check_gap("postrst k1");
    check_gap("postrst k2");
    chk("scoreboard drained", gap_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frac_baud_gen.md
FRAC_BAUD_GEN -- requirements
Module: frac_baud_gen

Interface
REQ-001 Parameter CNT_W, default 16, width of integer divisor and period counter.
REQ-002 Parameter FRAC_W, default 4, width of fractional divisor and fractional accumulator.
REQ-003 Parameter OVS, default 16, oversample ticks per bit; power of two, >= 4.
REQ-004 clock  input  1  single clock, all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  high = count; low = freeze all counters, no ticks.
REQ-007 restart  input  1  one-cycle pulse; realigns bit phase (RX start-bit detect).
REQ-008 load  input  1  one-cycle pulse; captures div_int/div_frac into pending register.
REQ-009 div_int  input  CNT_W  integer part of clocks per oversample tick.
REQ-010 div_frac  input  FRAC_W  fractional part, units of 1/2^FRAC_W clock.
REQ-011 tick_ovs  output  1  one-cycle oversample tick.
REQ-012 tick_mid  output  1  tick_ovs at bit midpoint (RX sample strobe).
REQ-013 tick_bit  output  1  tick_ovs at last oversample slot of a bit (TX bit strobe).
REQ-014 phase  output  $clog2(OVS)  current oversample slot within bit.
REQ-015 cfg_pending  output  1  high while a loaded divisor awaits application.

Function
REQ-016 Period counter SHALL start at 1, increment each enabled cycle, and return to 1 on the cycle tick_ovs is high.
REQ-017 tick_ovs SHALL be high, decoded from registered state with zero latency, in any enabled cycle where counter equals active period P = active_int + carry.
REQ-018 On each tick_ovs, fractional accumulator SHALL update acc <= acc + active_frac modulo 2^FRAC_W; carry-out SHALL set carry=1 for the next period only, else carry=0.
REQ-019 Long-run mean period SHALL equal active_int + active_frac/2^FRAC_W clocks, with no cumulative drift.
REQ-020 active_int values 0 or 1 SHALL be treated as 2 (minimum period 2 clocks).
REQ-021 phase SHALL increment on each tick_ovs and wrap from OVS-1 to 0.
REQ-022 tick_bit SHALL equal tick_ovs AND phase==OVS-1; tick_mid SHALL equal tick_ovs AND phase==OVS/2-1.
REQ-023 load SHALL copy div_int/div_frac into pending and set cfg_pending; a second load before application SHALL overwrite pending.
REQ-024 Pending SHALL transfer to active on the next tick_ovs cycle (governing the following period), or on the next cycle if enable is low; cfg_pending SHALL clear in that same cycle.
REQ-025 load coinciding with tick_ovs SHALL be captured into pending and applied at the following tick, not the current one.
REQ-026 restart SHALL set counter=1, acc=0, carry=0, phase=0, and suppress all ticks that cycle; restart SHALL override tick and enable.
REQ-027 enable low SHALL hold counter, acc, carry, phase unchanged and force all tick outputs low.

Reset
REQ-028 reset SHALL set counter=1, acc=0, carry=0, phase=0, cfg_pending=0, all ticks low.
REQ-029 reset SHALL load active and pending divisors from package defaults (54, frac 4: 115200 baud x16 at 100 MHz).
REQ-030 reset SHALL take priority over restart, load and enable.

Structure
REQ-031 Package baud_pkg SHALL hold CLK_HZ=100_000_000, DEF_DIV_INT=54, DEF_DIV_FRAC=4, DEF_OVS=16 and default widths.
REQ-032 Fractional accumulator and carry SHALL be a sub-module frac_acc (FRAC_W parameter, inputs step/frac/clear, output carry).
REQ-033 No other sub-modules; phase counter and config shadow stay in the top.

Verification
REQ-034 Reset, enable=1, defaults: tick_ovs gaps repeat 54,54,54,55 clocks; 16 ticks span 868 clocks; tick_bit every 16th tick_ovs.
REQ-035 load div_int=10, div_frac=0 mid-period: current period completes at old value, next gap = 10, cfg_pending high until that tick.
REQ-036 restart at phase=9: no tick that cycle, phase=0, first tick_mid after 8 further tick_ovs, first tick_bit after 16.
REQ-037 div_int=0 loaded: period clamps to 2; tick_ovs every other cycle; enable low 5 cycles mid-period extends gap by exactly 5.
REQ-038 reset asserted mid-period with pending load: all outputs low, cfg_pending=0, divisor back to 54/4, counting resumes from 1.
